// File: rtl/input_conditioner_if.sv
// Switch-conditioner bus: raw switch inputs and debounce enable in,
// conditioned levels and edge events out.
interface input_conditioner_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_io_sw;
  logic             i_db_en;
  logic [WIDTH-1:0] o_io_sw;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic             o_change;

  // Pin/top-level side: drives the raw inputs, consumes the conditioned view.
  modport master (
    output i_io_sw,
    output i_db_en,
    input  o_io_sw,
    input  o_rise,
    input  o_fall,
    input  o_change
  );

  // Conditioner side.
  modport slave (
    input  i_io_sw,
    input  i_db_en,
    output o_io_sw,
    output o_rise,
    output o_fall,
    output o_change
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel switch conditioner: synchroniser chain, counter debouncer with
// bypass, and registered rise/fall/change event pulses.
//
// The o_io_sw register closes the synchroniser chain: SYNC_STAGES-1 plain
// flops feed it, so in bypass a new input reaches o_io_sw SYNC_STAGES-1 edges
// after the edge that first samples it, and a clean step is accepted
// SYNC_STAGES+DB_CYCLES-2 edges after that first sample.
module input_conditioner #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000,
  parameter int CNT_W       = $clog2(DB_CYCLES + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input_conditioner_if.slave   bus
);

  localparam int              PRE_STAGES = SYNC_STAGES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CYCLES - 1);

  logic [PRE_STAGES-1:0][WIDTH-1:0] sync_chain_p0;
  logic [WIDTH-1:0]                 sync_p0;
  logic [CNT_W-1:0]                 cnt_q [WIDTH];
  logic [CNT_W-1:0]                 cnt_d [WIDTH];
  logic [WIDTH-1:0]                 sw_nxt;
  logic [WIDTH-1:0]                 sw_p1;
  logic [WIDTH-1:0]                 rise_p1;
  logic [WIDTH-1:0]                 fall_p1;
  logic                             change_p1;

  // Stage p0: metastability shift chain, no logic between flops.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_chain_p0 <= '0;
    end else begin
      sync_chain_p0[0] <= bus.i_io_sw;
      for (int s = 1; s < PRE_STAGES; s++) begin
        sync_chain_p0[s] <= sync_chain_p0[s-1];
      end
    end
  end

  assign sync_p0 = sync_chain_p0[PRE_STAGES-1];

  // Debounce decision: next level and next count per channel.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      sw_nxt[i] = sw_p1[i];
      cnt_d[i]  = '0;
      if (!bus.i_db_en) begin
        sw_nxt[i] = sync_p0[i];
      end else if (sync_p0[i] != sw_p1[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_nxt[i] = sync_p0[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce counters; a return to the stable value or bypass clears them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Stage p1: accepted level and edge pulses, aligned to the level change.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sw_p1     <= '0;
      rise_p1   <= '0;
      fall_p1   <= '0;
      change_p1 <= 1'b0;
    end else begin
      sw_p1     <= sw_nxt;
      rise_p1   <= sw_nxt & ~sw_p1;
      fall_p1   <= ~sw_nxt & sw_p1;
      change_p1 <= |(sw_nxt ^ sw_p1);
    end
  end

  assign bus.o_io_sw  = sw_p1;
  assign bus.o_rise   = rise_p1;
  assign bus.o_fall   = fall_p1;
  assign bus.o_change = change_p1;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random stimulus, all
// checked against a history-window reference model.
module tb_input_conditioner;

  localparam int WIDTH = 4;
  localparam int SS    = 2;
  localparam int DB    = 4;
  localparam int MAXE  = 4096;

  logic i_clk = 1'b0;
  logic i_reset;

  input_conditioner_if #(.WIDTH(WIDTH)) bus ();

  input_conditioner #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SS),
    .DB_CYCLES(DB)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per-edge history since the last reset release.
  logic [WIDTH-1:0] raw_h [MAXE];
  logic [WIDTH-1:0] syn_h [MAXE];
  logic             en_h  [MAXE];
  int               last_ev [WIDTH];
  int               t;
  logic [WIDTH-1:0] m_sw, m_rise, m_fall;
  logic             m_chg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    m_sw   = '0;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
    for (int c = 0; c < WIDTH; c++) last_ev[c] = -1;
  endtask

  // A channel is accepted when its synced value has differed from the stable
  // level on each of the last DB enabled edges, all after its last event.
  task automatic model_edge(input logic [WIDTH-1:0] in, input logic en);
    logic [WIDTH-1:0] syn, nxt;
    logic ok;
    int e;
    syn = (t - (SS - 1) >= 0) ? raw_h[t-(SS-1)] : '0;
    raw_h[t] = in;
    syn_h[t] = syn;
    en_h[t]  = en;
    nxt = m_sw;
    for (int c = 0; c < WIDTH; c++) begin
      if (!en) begin
        nxt[c] = syn[c];
        last_ev[c] = t;
      end else begin
        ok = 1'b1;
        for (int k = 0; k < DB; k++) begin
          e = t - k;
          if (e < 0 || e <= last_ev[c]) ok = 1'b0;
          else if (!en_h[e] || syn_h[e][c] == m_sw[c]) ok = 1'b0;
        end
        if (ok) begin
          nxt[c] = ~m_sw[c];
          last_ev[c] = t;
        end
      end
    end
    m_rise = nxt & ~m_sw;
    m_fall = ~nxt & m_sw;
    m_chg  = |(nxt ^ m_sw);
    m_sw   = nxt;
    if (t < MAXE - 1) t++;
  endtask

  // One clock: drive at negedge, model the posedge, check just after it.
  task automatic step(input logic [WIDTH-1:0] in, input logic en);
    @(negedge i_clk);
    bus.i_io_sw = in;
    bus.i_db_en = en;
    @(posedge i_clk);
    model_edge(in, en);
    #1;
    chk("sw",     32'(bus.o_io_sw),  32'(m_sw));
    chk("rise",   32'(bus.o_rise),   32'(m_rise));
    chk("fall",   32'(bus.o_fall),   32'(m_fall));
    chk("change", 32'(bus.o_change), 32'(m_chg));
    chk("excl",   32'(bus.o_rise & bus.o_fall), 32'(0));
  endtask

  int rise_cnt, other_cnt, found, hold;
  logic [WIDTH-1:0] rnd_in;
  logic             rnd_en;

  initial begin
    i_reset     = 1'b1;
    bus.i_io_sw = '0;
    bus.i_db_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_sw",     32'(bus.o_io_sw),  32'(0));
    chk("rst_rise",   32'(bus.o_rise),   32'(0));
    chk("rst_fall",   32'(bus.o_fall),   32'(0));
    chk("rst_change", 32'(bus.o_change), 32'(0));
    i_reset = 1'b0;
    model_reset();

    // Establish a nonzero level, then reset asynchronously mid-count.
    repeat (8) step(4'hA, 1'b1);
    chk("pre_sw", 32'(bus.o_io_sw), 32'hA);
    repeat (2) step(4'hF, 1'b1);
    @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    chk("async_sw",     32'(bus.o_io_sw),  32'(0));
    chk("async_rise",   32'(bus.o_rise),   32'(0));
    chk("async_change", 32'(bus.o_change), 32'(0));
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    chk("held_sw", 32'(bus.o_io_sw), 32'(0));
    i_reset = 1'b0;
    model_reset();

    // Inputs high at release: accepted after edge 4.
    for (int e = 0; e < 6; e++) begin
      step(4'hF, 1'b1);
      if (e == 3) chk("t1_e3_sw", 32'(bus.o_io_sw), 32'(0));
      if (e == 4) begin
        chk("t1_e4_sw",   32'(bus.o_io_sw),  32'hF);
        chk("t1_e4_rise", 32'(bus.o_rise),   32'hF);
        chk("t1_e4_chg",  32'(bus.o_change), 32'(1));
      end
      if (e == 5) chk("t1_e5_rise", 32'(bus.o_rise), 32'(0));
    end

    // Clean step on ch0.
    repeat (8) step(4'h0, 1'b1);
    rise_cnt = 0;
    other_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      step(4'h1, 1'b1);
      rise_cnt  += int'(bus.o_rise[0]);
      other_cnt += int'(|(bus.o_rise[3:1] | bus.o_fall[3:1]));
    end
    chk("t2_rise_cnt", 32'(rise_cnt), 32'(1));
    chk("t2_other",    32'(other_cnt), 32'(0));
    chk("t2_sw",       32'(bus.o_io_sw), 32'h1);

    // Glitch on ch1 of 3 cycles is rejected, 4 cycles is accepted.
    repeat (3) step(4'h3, 1'b1);
    rise_cnt = 0;
    for (int e = 0; e < 8; e++) begin
      step(4'h1, 1'b1);
      rise_cnt += int'(bus.o_rise[1]);
    end
    chk("t3_glitch_sw",   32'(bus.o_io_sw), 32'h1);
    chk("t3_glitch_rise", 32'(rise_cnt), 32'(0));
    rise_cnt = 0;
    repeat (4) step(4'h3, 1'b1);
    for (int e = 0; e < 8; e++) begin
      step(4'h1, 1'b1);
      rise_cnt += int'(bus.o_rise[1]);
    end
    chk("t3_accept_rise", 32'(rise_cnt), 32'(1));

    // Bypass: one-cycle pulse on ch2 passes straight through.
    repeat (3) step(4'h1, 1'b0);
    step(4'h5, 1'b0);
    step(4'h1, 1'b0);
    chk("t4_sw_hi",  32'(bus.o_io_sw[2]), 32'(1));
    chk("t4_rise",   32'(bus.o_rise),     32'h4);
    step(4'h1, 1'b0);
    chk("t4_sw_lo",  32'(bus.o_io_sw[2]), 32'(0));
    chk("t4_fall",   32'(bus.o_fall),     32'h4);

    // Simultaneous ch0 fall and ch3 rise.
    repeat (2) step(4'h1, 1'b1);
    found = 0;
    for (int e = 0; e < 8; e++) begin
      step(4'h8, 1'b1);
      if (bus.o_change) begin
        found++;
        chk("t5_fall", 32'(bus.o_fall), 32'h1);
        chk("t5_rise", 32'(bus.o_rise), 32'h8);
      end
    end
    chk("t5_events", 32'(found), 32'(1));

    // Mode switch mid-count: bypass follows sync, then a fresh count.
    step(4'h8, 1'b1);
    repeat (2) step(4'hA, 1'b1);
    step(4'hA, 1'b0);
    chk("t6_follow", 32'(bus.o_io_sw), 32'hA);
    for (int e = 0; e < 5; e++) begin
      step(4'h8, 1'b1);
      if (e == 3) chk("t6_still", 32'(bus.o_io_sw[1]), 32'(1));
      if (e == 4) chk("t6_accept", 32'(bus.o_io_sw[1]), 32'(0));
    end

    // Random stimulus with random hold lengths and occasional bypass.
    for (int r = 0; r < 120; r++) begin
      rnd_in = WIDTH'($urandom);
      rnd_en = ($urandom_range(0, 7) != 0);
      hold   = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) step(rnd_in, rnd_en);
    end
    repeat (8) step(4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
